// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - walks the register file and streams each register out over valid/ready
// Also snoops register-file writes and flags a dump that is no longer a consistent snapshot.
module reg_dump_reader #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 16
) (
  input  logic              Clk,
  input  logic              Reset_ah,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              snoop_ld,
  input  logic [ADDR_W-1:0] snoop_dr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              stale
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic              snoop_hit;

  assign rd_addr = idx;

  // A write at or below the current index lands on a register already captured
  // (or being captured this cycle, where rd_data still shows the old value).
  assign snoop_hit = snoop_ld && (snoop_dr <= idx) && (snoop_dr <= LAST_IDX) &&
                     ((state == FETCH) || (state == SEND));

  always_ff @(posedge Clk) begin
    if (Reset_ah) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      stale     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (snoop_hit) begin
        stale <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= '0;
            stale <= 1'b0;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH: begin
          out_data  <= rd_data;
          out_idx   <= idx;
          out_last  <= (idx == LAST_IDX);
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= FETCH;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb/tb_reg_dump_reader.sv - self-checking bench for reg_dump_reader with a behavioural register file
module tb_reg_dump_reader;

  logic        Clk = 1'b0;
  logic        Reset_ah;
  logic        start;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic        snoop_ld;
  logic [2:0]  snoop_dr;
  logic [15:0] snoop_wd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        stale;

  logic        init;
  logic [15:0] regs [8];
  logic [15:0] exp_mem [8];

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  reg_dump_reader #(.NUM_REGS(8), .ADDR_W(3), .DATA_W(16)) dut (
    .Clk(Clk), .Reset_ah(Reset_ah), .start(start),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .snoop_ld(snoop_ld), .snoop_dr(snoop_dr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .done(done), .stale(stale)
  );

  always @(posedge Clk) begin
    if (init) begin
      for (int i = 0; i < 8; i++) regs[i] <= 16'h1000 + 16'(i);
    end else if (snoop_ld) begin
      regs[snoop_dr] <= snoop_wd;
    end
  end
  assign rd_data = regs[rd_addr];

  typedef struct {
    logic        start;
    logic        ready;
    logic        e_valid;
    logic [15:0] e_data;
    logic [2:0]  e_idx;
    logic        e_last;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t t1 [18];

  task automatic cyc();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic init_all();
    init = 1'b1;
    cyc();
    init = 1'b0;
    for (int i = 0; i < 8; i++) exp_mem[i] = 16'h1000 + 16'(i);
  endtask

  // Runs one dump from a start pulse; optional stall, snoop write, start spam or mid-dump reset.
  task automatic drain(input int stall_idx, input int wr_idx, input bit wr_fetch,
                       input logic [2:0] dr, input logic [15:0] val, input bit spam,
                       input int rst_idx, output int n, output int dones);
    int stall_left;
    bit fired;
    bit fin;
    n = 0;
    dones = 0;
    stall_left = (stall_idx >= 0) ? 5 : 0;
    fired = 0;
    fin = 0;
    out_ready = 1'b1;
    start = 1'b1;
    cyc();
    start = spam;
    for (int c = 0; c < 200 && !fin; c++) begin
      snoop_ld = 1'b0;
      out_ready = 1'b1;
      if (!fired && wr_idx >= 0 &&
          (wr_fetch ? (busy && !out_valid && !done && n == wr_idx)
                    : (out_valid && 32'(out_idx) == wr_idx))) begin
        snoop_ld = 1'b1;
        snoop_dr = dr;
        snoop_wd = val;
        fired = 1;
        if (!wr_fetch) exp_mem[dr] = val;
      end
      if (!busy) begin
        fin = 1;
        start = 1'b0;
      end else if (rst_idx >= 0 && out_valid && 32'(out_idx) == rst_idx) begin
        out_ready = 1'b0;
        Reset_ah = 1'b1;
        cyc();
        Reset_ah = 1'b0;
        fin = 1;
      end else begin
        if (out_valid && 32'(out_idx) == stall_idx && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_data", 32'(out_data), 32'(exp_mem[stall_idx[2:0]]));
          chk("stall_idx", 32'(out_idx), 32'(stall_idx));
        end else if (out_valid) begin
          chk("beat_idx", 32'(out_idx), 32'(n));
          chk("beat_data", 32'(out_data), 32'(exp_mem[n[2:0]]));
          chk("beat_last", 32'(out_last), 32'(n == 7));
          n++;
        end
        if (done) dones++;
        cyc();
      end
    end
    if (!fin) chk("drain_timeout", 32'd0, 32'd1);
    snoop_ld = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
    chk({tag, "_idx"}, 32'(out_idx), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_stale"}, 32'(stale), 32'd0);
    chk({tag, "_rdaddr"}, 32'(rd_addr), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int d;
    Reset_ah = 1'b1;
    start = 1'b0;
    snoop_ld = 1'b0;
    snoop_dr = '0;
    snoop_wd = '0;
    out_ready = 1'b0;
    init = 1'b0;
    @(negedge Clk);
    init_all();
    cyc();
    chk_zero("reset");
    Reset_ah = 1'b0;
    cyc();

    // Zero-stall dump: vector i drives the edge, expectation is the state after it.
    for (int i = 0; i < 18; i++) begin
      t1[i].start   = (i == 0);
      t1[i].ready   = 1'b1;
      t1[i].e_valid = (i % 2 == 1) && (i <= 15);
      t1[i].e_data  = 16'h1000 + 16'((i - 1) / 2);
      t1[i].e_idx   = 3'((i - 1) / 2);
      t1[i].e_last  = (i == 15);
      t1[i].e_busy  = (i <= 16);
      t1[i].e_done  = (i == 16);
    end
    for (int i = 0; i < 18; i++) begin
      start = t1[i].start;
      out_ready = t1[i].ready;
      cyc();
      chk("t1_valid", 32'(out_valid), 32'(t1[i].e_valid));
      chk("t1_busy", 32'(busy), 32'(t1[i].e_busy));
      chk("t1_done", 32'(done), 32'(t1[i].e_done));
      chk("t1_stale", 32'(stale), 32'd0);
      if (t1[i].e_valid) begin
        chk("t1_data", 32'(out_data), 32'(t1[i].e_data));
        chk("t1_idx", 32'(out_idx), 32'(t1[i].e_idx));
        chk("t1_last", 32'(out_last), 32'(t1[i].e_last));
      end
    end
    start = 1'b0;

    init_all();
    drain(3, -1, 1'b0, 3'd0, 16'h0, 1'b0, -1, n, d);
    chk("t2_beats", 32'(n), 32'd8);
    chk("t2_dones", 32'(d), 32'd1);
    chk("t2_stale", 32'(stale), 32'd0);

    init_all();
    drain(-1, 5, 1'b0, 3'd6, 16'h6006, 1'b0, -1, n, d);
    chk("t3a_beats", 32'(n), 32'd8);
    chk("t3a_stale", 32'(stale), 32'd0);
    init_all();
    drain(-1, 5, 1'b0, 3'd2, 16'hBEEF, 1'b0, -1, n, d);
    chk("t3b_beats", 32'(n), 32'd8);
    chk("t3b_stale", 32'(stale), 32'd1);
    init_all();
    chk("t3b_stale_held", 32'(stale), 32'd1);
    drain(-1, -1, 1'b0, 3'd0, 16'h0, 1'b0, -1, n, d);
    chk("t3c_beats", 32'(n), 32'd8);
    chk("t3c_stale", 32'(stale), 32'd0);

    init_all();
    drain(-1, 4, 1'b1, 3'd4, 16'h4444, 1'b0, -1, n, d);
    chk("t4_beats", 32'(n), 32'd8);
    chk("t4_stale", 32'(stale), 32'd1);

    init_all();
    drain(-1, 2, 1'b0, 3'd1, 16'h1111, 1'b0, 4, n, d);
    chk("t5_beats_before_reset", 32'(n), 32'd4);
    chk_zero("t5_after_reset");
    cyc();
    drain(-1, -1, 1'b0, 3'd0, 16'h0, 1'b0, -1, n, d);
    chk("t5_redump_beats", 32'(n), 32'd8);
    chk("t5_redump_dones", 32'(d), 32'd1);

    init_all();
    drain(-1, -1, 1'b0, 3'd0, 16'h0, 1'b1, -1, n, d);
    chk("t6_beats", 32'(n), 32'd8);
    chk("t6_dones", 32'(d), 32'd1);
    repeat (5) cyc();
    chk("t6_idle_busy", 32'(busy), 32'd0);
    chk("t6_idle_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
